// File: rtl/rf_pkg.sv
// Shared defaults and types for the multi-port integer register file.
package rf_pkg;

  localparam int XLEN_DEF   = 64;
  localparam int DEPTH_DEF  = 32;
  localparam int NUM_RD_DEF = 2;
  localparam int ZERO_REG   = 0;

  localparam int AW_DEF = $clog2(DEPTH_DEF);

  typedef logic [AW_DEF-1:0]   rf_addr_t;
  typedef logic [XLEN_DEF-1:0] rf_data_t;

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register pending bits: decode sets them on issue, writeback clears them on retire.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             iss_en,
  input  logic [$clog2(DEPTH)-1:0]         iss_addr,
  input  logic                             wr_en,
  input  logic [$clog2(DEPTH)-1:0]         wr_addr,
  input  logic [NUM_RD*$clog2(DEPTH)-1:0]  rd_addr,
  output logic [NUM_RD-1:0]                rd_busy
);

  localparam int AW = $clog2(DEPTH);

  logic [DEPTH-1:0] busy_q;
  logic [DEPTH-1:0] busy_d;

  logic wr_hit;
  logic iss_hit;

  assign wr_hit  = wr_en  && (wr_addr  != AW'(ZERO_REG));
  assign iss_hit = iss_en && (iss_addr != AW'(ZERO_REG));

  // Clear first, then set: a same-cycle issue to the retiring register names a new producer.
  always_comb begin
    busy_d = busy_q;
    if (wr_hit) begin
      busy_d[wr_addr] = 1'b0;
    end
    if (iss_hit) begin
      busy_d[iss_addr] = 1'b1;
    end
    busy_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_busy
    logic [AW-1:0] addr;
    assign addr       = rd_addr[g*AW +: AW];
    // A retiring write hides the flag in the same cycle, matching the data bypass.
    assign rd_busy[g] = rst_n && busy_q[addr] && !(wr_en && (wr_addr == addr));
  end

endmodule

// File: rtl/regfile_mp.sv
// Parametrised register file: NUM_RD combinational read ports with write bypass,
// one synchronous write port, hardwired-zero x0 and a pending-write scoreboard.
module regfile_mp
  import rf_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int NUM_RD = NUM_RD_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic [NUM_RD*$clog2(DEPTH)-1:0]  rd_addr,
  output logic [NUM_RD*XLEN-1:0]           rd_data,
  output logic [NUM_RD-1:0]                rd_busy,
  input  logic                             wr_en,
  input  logic [$clog2(DEPTH)-1:0]         wr_addr,
  input  logic [XLEN-1:0]                  wr_data,
  input  logic                             iss_en,
  input  logic [$clog2(DEPTH)-1:0]         iss_addr
);

  localparam int AW = $clog2(DEPTH);

  logic [XLEN-1:0] regs_q [DEPTH];
  logic [XLEN-1:0] regs_d [DEPTH];

  logic wr_hit;
  assign wr_hit = wr_en && (wr_addr != AW'(ZERO_REG));

  always_comb begin
    regs_d = regs_q;
    if (wr_hit) begin
      regs_d[wr_addr] = wr_data;
    end
  end

  // Entry 0 is only ever reset, so it holds zero; reads of x0 are forced to zero anyway.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [AW-1:0] addr;
    assign addr = rd_addr[g*AW +: AW];
    assign rd_data[g*XLEN +: XLEN] =
      (!rst_n || (addr == AW'(ZERO_REG))) ? '0 :
      (wr_en && (wr_addr == addr))        ? wr_data :
                                            regs_q[addr];
  end

  rf_scoreboard #(
    .DEPTH  (DEPTH),
    .NUM_RD (NUM_RD)
  ) u_scoreboard (
    .clk      (clk),
    .rst_n    (rst_n),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .rd_addr  (rd_addr),
    .rd_busy  (rd_busy)
  );

endmodule
